// File: rtl/booth_mul_seq_arb_if.sv
// booth_mul_seq_arb_if: two operand request channels plus the tagged response channel.
// master = requesters/consumer side, slave = the multiply engine.
interface booth_mul_seq_arb_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [7:0]  req0_m;
  logic [7:0]  req0_M;
  logic        req1_valid;
  logic        req1_ready;
  logic [7:0]  req1_m;
  logic [7:0]  req1_M;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_result;
  logic        busy;
  modport master (
    output req0_valid, req0_m, req0_M, req1_valid, req1_m, req1_M, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, busy
  );
  modport slave (
    input  req0_valid, req0_m, req0_M, req1_valid, req1_m, req1_M, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, busy
  );
endinterface

// File: rtl/booth_mul_seq_arb.sv
// booth_mul_seq_arb: shared radix-4 Booth 8x8 signed multiplier, one partial product per cycle.
// Define BOOTH_MUL_SEQ_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module booth_mul_seq_arb (
  input logic                 clk,
  input logic                 rst_n,
  booth_mul_seq_arb_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q;
  logic [1:0]  k_q;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  m_q, mc_q;
  logic        rsp_valid_q, rsp_id_q, busy_q;
  logic [15:0] rsp_result_q;
  logic        grant, accept, idle;
  logic [8:0]  mx;
  logic [2:0]  d;
  logic [15:0] mse, mag, pp;
`ifdef BOOTH_MUL_SEQ_ARB_RR_EN
  logic        last_grant_q;
  assign grant = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : ~bus.req0_valid;
`else
  assign grant = ~bus.req0_valid;
`endif
  assign idle           = state_q == IDLE;
  assign bus.req0_ready = idle & ~grant & bus.req0_valid;
  assign bus.req1_ready = idle & grant & bus.req1_valid;
  assign accept         = bus.req0_ready | bus.req1_ready;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.busy       = busy_q;
  // m[-1] = 0 is supplied by the appended zero
  assign mx  = {m_q, 1'b0};
  assign d   = mx[{k_q, 1'b0} +: 3];
  assign mse = {{8{mc_q[7]}}, mc_q};
  assign mag = (d == 3'b011 || d == 3'b100) ? mse << 1 : (d == 3'b000 || d == 3'b111) ? 16'h0000 : mse;
  assign pp  = (d[2] ? -mag : mag) << {k_q, 1'b0};
  assign acc_d = acc_q + pp;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      k_q          <= 2'd0;
      acc_q        <= 16'h0000;
      m_q          <= 8'h00;
      mc_q         <= 8'h00;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 16'h0000;
      busy_q       <= 1'b0;
`ifdef BOOTH_MUL_SEQ_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          state_q  <= RUN;
          m_q      <= grant ? bus.req1_m : bus.req0_m;
          mc_q     <= grant ? bus.req1_M : bus.req0_M;
          rsp_id_q <= grant;
          acc_q    <= 16'h0000;
          k_q      <= 2'd0;
          busy_q   <= 1'b1;
`ifdef BOOTH_MUL_SEQ_ARB_RR_EN
          last_grant_q <= grant;
`endif
        end
        RUN: begin
          acc_q <= acc_d;
          k_q   <= k_q + 2'd1;
          if (k_q == 2'd3) begin
            state_q      <= DONE;
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= acc_d;
          end
        end
        DONE: if (bus.rsp_ready) begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mul_seq_arb.sv
// tb_booth_mul_seq_arb: directed vector table, arbitration, backpressure, mid-run reset and random sweep.
module tb_booth_mul_seq_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  booth_mul_seq_arb_if bus ();
  booth_mul_seq_arb dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int vecs = 0;
  int miscompares = 0;
  typedef struct {
    bit         id;
    logic [7:0] m;
    logic [7:0] mc;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic accept_op(input bit id, input logic [7:0] m, input logic [7:0] mc);
    int n = 0;
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_m = m; bus.req1_M = mc;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_m = m; bus.req0_M = mc;
    end
    #1;
    while (!(id ? bus.req1_ready : bus.req0_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("accept_wait", n < 20, 1);
    chk("other_ready", id ? bus.req0_ready : bus.req1_ready, 0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input bit id, input logic [15:0] exp, input int stall, input string nm);
    int n = 0;
    bus.rsp_ready = (stall == 0);
    do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 20);
    chk({nm, "_lat"}, n, 5);
    chk({nm, "_res"}, bus.rsp_result, exp);
    chk({nm, "_id"}, bus.rsp_id, id);
    for (int i = 0; i < stall; i++) @(negedge clk);
    if (stall > 0) chk({nm, "_hold"}, {bus.rsp_valid, bus.rsp_result}, {1'b1, exp});
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_idle"}, {bus.rsp_valid, bus.busy}, 2'b00);
  endtask

  task automatic do_op(input bit id, input logic [7:0] m, input logic [7:0] mc,
                       input logic [15:0] exp, input int stall, input string nm);
    accept_op(id, m, mc);
    wait_rsp(id, exp, stall, nm);
  endtask

  initial begin
    int n, cnt, p;
    bit g[4];
    bit eg[4];
    bit rid;
    logic [7:0] rm, rmc;
    tbl[0] = '{1'b0, 8'h03, 8'h05, 16'h000F};
    tbl[1] = '{1'b1, 8'h80, 8'h80, 16'h4000};
    tbl[2] = '{1'b0, 8'h7F, 8'h80, 16'hC080};
    tbl[3] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
    tbl[4] = '{1'b0, 8'h00, 8'h7F, 16'h0000};
    tbl[5] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
    tbl[6] = '{1'b0, 8'h80, 8'h7F, 16'hC080};
    tbl[7] = '{1'b1, 8'hFE, 8'h07, 16'hFFF2};
    tbl[8] = '{1'b0, 8'h55, 8'hAA, 16'hE372};
    tbl[9] = '{1'b1, 8'h10, 8'h10, 16'h0100};
    bus.req0_valid = 1'b0; bus.req0_m = 8'h00; bus.req0_M = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_m = 8'h00; bus.req1_M = 8'h00;
    bus.rsp_ready = 1'b1;
    #12;
    chk("rst_outs", {bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.busy}, 5'b0);
    chk("rst_result", bus.rsp_result, 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // both requesters held valid: record who is granted on each accept
    bus.req0_valid = 1'b1; bus.req0_m = 8'd2; bus.req0_M = 8'd3;
    bus.req1_valid = 1'b1; bus.req1_m = 8'd4; bus.req1_M = 8'd5;
    cnt = 0; n = 0;
    while (cnt < 4 && n < 60) begin
      #1;
      chk("arb_onehot", bus.req0_ready & bus.req1_ready, 0);
      if (bus.req0_ready | bus.req1_ready) begin g[cnt] = bus.req1_ready; cnt++; end
      if (bus.rsp_valid) chk("arb_res", bus.rsp_result, bus.rsp_id ? 16'd20 : 16'd6);
      @(negedge clk); n++;
    end
    chk("arb_count", cnt, 4);
`ifdef BOOTH_MUL_SEQ_ARB_RR_EN
    eg = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    eg = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 4; i++) chk($sformatf("arb_grant%0d", i), g[i], eg[i]);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("arb_drain", {bus.rsp_valid, bus.busy}, 2'b00);

    for (int i = 0; i < 10; i++)
      do_op(tbl[i].id, tbl[i].m, tbl[i].mc, tbl[i].exp, 0, $sformatf("vec%0d", i));

    // backpressure: result held, no accepts while DONE
    accept_op(1'b0, 8'd9, 8'd9);
    bus.rsp_ready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 20);
    chk("bp_lat", n, 5);
    bus.req0_valid = 1'b1; bus.req0_m = 8'd2; bus.req0_M = 8'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_result}, {1'b1, 1'b0, 16'h0051});
      chk("bp_rdy", {bus.req0_ready, bus.req1_ready}, 2'b00);
      chk("bp_busy", bus.busy, 1);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle", {bus.rsp_valid, bus.busy, bus.req0_ready}, 3'b001);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    wait_rsp(1'b0, 16'h0006, 0, "bp_next");

    // asynchronous reset during RUN k=2
    accept_op(1'b0, 8'd50, 8'd3);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_outs", {bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.busy}, 5'b0);
    chk("mrst_result", bus.rsp_result, 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    repeat (8) begin @(negedge clk); n += int'(bus.rsp_valid); end
    chk("mrst_norsp", n, 0);
    do_op(1'b0, 8'hFE, 8'h07, 16'hFFF2, 0, "mrst_after");

    for (int i = 0; i < 1000; i++) begin
      rid = 1'($urandom_range(0, 1));
      rm = 8'($urandom);
      rmc = 8'($urandom);
      p = $signed(rm) * $signed(rmc);
      do_op(rid, rm, rmc, p[15:0], int'($urandom_range(0, 3)), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
